// File: rtl/ai_multiplex.sv
// Four-lane byte packer: per-lane FIFOs feed a 40-bit {seq, flags, bytes} word on a valid/ready source.
// Optional feature macro: AI_MUX_DROP_CNT_EN adds a saturating drop_count output.
module ai_multiplex #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [7:0]  data1,
  input  logic [7:0]  data2,
  input  logic [7:0]  data3,
  input  logic [7:0]  data4,
  input  logic        data1_rdy,
  input  logic        data2_rdy,
  input  logic        data3_rdy,
  input  logic        data4_rdy,
  output logic [3:0]  lane_full,
  output logic [3:0]  overflow,
  output logic [39:0] avs_s2_inout,
  output logic        avs_s2_valid,
  input  logic        avs_s2_ready
`ifdef AI_MUX_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic {COLLECT, SEND} state_t;

  logic [7:0]    mem_q    [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [CW-1:0] cnt_q    [4];

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [3:0]    seq_q;
  logic [39:0]   word_q;
  logic [39:0]   word_d;
  logic          valid_q;
  logic [3:0]    ovf_q;

  logic [7:0] din [4];
  logic [3:0] push, not_empty, full, pop, push_ok, drop;
  logic       load;

  assign din[0] = data1;
  assign din[1] = data2;
  assign din[2] = data3;
  assign din[3] = data4;
  assign push   = {data4_rdy, data3_rdy, data2_rdy, data1_rdy};

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    not_empty = '0;
    full      = '0;
    for (int i = 0; i < 4; i++) begin
      not_empty[i] = (cnt_q[i] != '0);
      full[i]      = (cnt_q[i] == CW'(DEPTH));
    end
    load    = (state_q == COLLECT) &&
              ((&not_empty) || ((|not_empty) && (timer_q == TMAX)));
    pop     = load ? not_empty : 4'b0000;
    // A full lane still accepts a push when it is popped in the same cycle.
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
    word_d  = {seq_q, pop, 32'h0};
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) word_d[8*i +: 8] = mem_q[i][rd_ptr_q[i]];
    end
  end

  // NOTE: FIFO storage has no reset; the cleared counts and pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i] && !rst && !init) mem_q[i][wr_ptr_q[i]] <= din[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || init) begin
      state_q <= COLLECT;
      timer_q <= '0;
      seq_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
        if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
        cnt_q[i] <= cnt_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
      end
      ovf_q <= ovf_q | drop;

      unique case (state_q)
        COLLECT: begin
          if (!(|not_empty))     timer_q <= '0;
          else if (timer_q != TMAX) timer_q <= timer_q + TW'(1);
          if (load) begin
            word_q  <= word_d;
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (avs_s2_ready) begin
            seq_q   <= seq_q + 4'd1;
            timer_q <= '0;
            valid_q <= 1'b0;
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

`ifdef AI_MUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic [2:0]  drop_n;
  logic [16:0] drop_sum;

  always_comb begin
    drop_n   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    drop_sum = {1'b0, drop_cnt_q} + 17'(drop_n);
  end

  always_ff @(posedge clk) begin
    if (rst || init) drop_cnt_q <= '0;
    else             drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_count = drop_cnt_q;
`endif

  assign lane_full    = full;
  assign overflow     = ovf_q;
  assign avs_s2_inout = word_q;
  assign avs_s2_valid = valid_q;

endmodule

// File: tb/tb_ai_multiplex.sv
// Scoreboard bench for ai_multiplex: queue-based lane model predicts words; a negedge monitor compares.
module tb_ai_multiplex;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0;
  logic [7:0]  data1 = '0, data2 = '0, data3 = '0, data4 = '0;
  logic        rdy1 = 1'b0, rdy2 = 1'b0, rdy3 = 1'b0, rdy4 = 1'b0;
  logic [3:0]  lane_full, overflow;
  logic [39:0] avs_s2_inout;
  logic        avs_s2_valid;
  logic        avs_s2_ready = 1'b0;
`ifdef AI_MUX_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  ai_multiplex #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .init(init),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .data1_rdy(rdy1), .data2_rdy(rdy2), .data3_rdy(rdy3), .data4_rdy(rdy4),
    .lane_full(lane_full), .overflow(overflow),
    .avs_s2_inout(avs_s2_inout), .avs_s2_valid(avs_s2_valid),
    .avs_s2_ready(avs_s2_ready)
`ifdef AI_MUX_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, hs_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: lanes are bounded queues, a word is either pending or not.
  logic [7:0]  lq [4][$];
  bit          busy;
  int          wait_cnt, seq, m_drops;
  logic [3:0]  m_ovf;
  logic [39:0] sb [$];

  logic        exp_valid = 1'b0;
  logic [3:0]  exp_full = '0, exp_ovf = '0;
  int          exp_drops = 0;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) lq[i].delete();
    busy = 0; wait_cnt = 0; seq = 0; m_ovf = '0; m_drops = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic [3:0] p, input logic [31:0] bytes,
                            input logic rdy, input logic ini);
    int n;
    logic [39:0] w;
    if (ini) begin
      model_clear();
      return;
    end
    if (busy) begin
      if (rdy) begin
        busy = 0; seq = (seq + 1) % 16; wait_cnt = 0;
      end
    end else begin
      n = 0;
      for (int i = 0; i < 4; i++) if (lq[i].size() > 0) n++;
      if (n == 4 || (n > 0 && wait_cnt == TIMEOUT - 1)) begin
        w = '0;
        w[39:36] = seq[3:0];
        for (int i = 0; i < 4; i++) begin
          if (lq[i].size() > 0) begin
            w[32+i]    = 1'b1;
            w[8*i +: 8] = lq[i].pop_front();
          end
        end
        sb.push_back(w);
        busy = 1;
      end
      if (n == 0) wait_cnt = 0;
      else if (wait_cnt < TIMEOUT - 1) wait_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        if (lq[i].size() < DEPTH) lq[i].push_back(bytes[8*i +: 8]);
        else begin
          m_ovf[i] = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  endtask

  task automatic cycle(input logic [3:0] p, input logic [31:0] bytes,
                       input logic rdy, input logic ini);
    @(posedge clk); #1;
    {data4, data3, data2, data1} = bytes;
    {rdy4, rdy3, rdy2, rdy1}     = p;
    avs_s2_ready = rdy;
    init         = ini;
    exp_valid = busy;
    for (int i = 0; i < 4; i++) exp_full[i] = (lq[i].size() == DEPTH);
    exp_ovf   = m_ovf;
    exp_drops = m_drops;
    model_step(p, bytes, rdy, ini);
  endtask

  // Monitor: no handshake takes effect in a reset or init cycle, so those are skipped.
  always @(negedge clk) begin
    if (!rst && !init) begin
      check("valid", {63'b0, avs_s2_valid}, {63'b0, exp_valid});
      check("lane_full", {60'b0, lane_full}, {60'b0, exp_full});
      check("overflow", {60'b0, overflow}, {60'b0, exp_ovf});
`ifdef AI_MUX_DROP_CNT_EN
      check("drop_count", {48'b0, drop_count}, 64'(exp_drops));
`endif
      if (avs_s2_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL word: valid with no expected word pending, got 0x%0h", avs_s2_inout);
        end else begin
          check("word", {24'b0, avs_s2_inout}, {24'b0, sb[0]});
          if (avs_s2_ready) begin
            void'(sb.pop_front());
            hs_count++;
          end
        end
      end
    end
  end

  int hs0;
  logic [3:0] rp;

  initial begin
    model_clear();
    // Strobes during reset must be discarded.
    {data4, data3, data2, data1} = 32'h77777777;
    {rdy4, rdy3, rdy2, rdy1}     = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'b0, avs_s2_valid}, 64'd0);
    check("rst_word", {24'b0, avs_s2_inout}, 64'd0);
    check("rst_overflow", {60'b0, overflow}, 64'd0);
    check("rst_lane_full", {60'b0, lane_full}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    {rdy4, rdy3, rdy2, rdy1} = 4'h0;

    // All-lane burst: valid two cycles after the strobes.
    cycle(4'hF, 32'h44332211, 1'b1, 1'b0);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("burst_c1_valid", {63'b0, avs_s2_valid}, 64'd0);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("burst_valid", {63'b0, avs_s2_valid}, 64'd1);
    check("burst_word", {24'b0, avs_s2_inout}, 64'h0F44332211);
    cycle(4'h0, 32'h0, 1'b0, 1'b0);
    cycle(4'h0, 32'h0, 1'b0, 1'b1);

    // Partial word forced out by the timeout.
    cycle(4'b0100, 32'h00A50000, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cycle(4'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      if (k == 8) check("timeout_early", {63'b0, avs_s2_valid}, 64'd0);
      if (k == 9) begin
        check("timeout_valid", {63'b0, avs_s2_valid}, 64'd1);
        check("timeout_word", {24'b0, avs_s2_inout}, 64'h0400A50000);
      end
    end

    // Stall: lane1 fills, lane2 overflows by two.
    for (int k = 0; k < 20; k++) begin
      rp = (k < 4) ? 4'b0001 : ((k < 10) ? 4'b0010 : 4'b0000);
      cycle(rp, {16'h0, 8'(8'h60 + k), 8'(8'h30 + k)}, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("stall_valid", {63'b0, avs_s2_valid}, 64'd1);
    check("stall_lane_full", {60'b0, lane_full}, 64'b0011);
    check("stall_overflow", {60'b0, overflow}, 64'b0010);
`ifdef AI_MUX_DROP_CNT_EN
    check("stall_drop_count", {48'b0, drop_count}, 64'd2);
`endif
    repeat (60) cycle(4'h0, 32'h0, 1'b1, 1'b0);
    check("stall_drained", 64'(sb.size()), 64'd0);

    // init while a word is presented.
    cycle(4'hF, 32'hDDCCBBAA, 1'b0, 1'b0);
    cycle(4'h0, 32'h0, 1'b0, 1'b0);
    cycle(4'b0001, 32'h0000005A, 1'b0, 1'b0);
    cycle(4'h0, 32'h0, 1'b0, 1'b1);
    cycle(4'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("init_valid", {63'b0, avs_s2_valid}, 64'd0);
    check("init_overflow", {60'b0, overflow}, 64'd0);
    check("init_lane_full", {60'b0, lane_full}, 64'd0);
    cycle(4'hF, 32'h87654321, 1'b1, 1'b0);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    cycle(4'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("init_seq_word", {24'b0, avs_s2_inout}, 64'h0F87654321);
    cycle(4'h0, 32'h0, 1'b0, 1'b1);

    // Sequence wrap at full throughput.
    hs0 = hs_count;
    for (int k = 0; k < 36; k++)
      cycle((k % 2 == 0 && k < 34) ? 4'hF : 4'h0, $urandom, 1'b1, 1'b0);
    check("wrap_word_count", 64'(hs_count - hs0), 64'd17);

    // Randomized traffic with occasional init.
    repeat (3000) begin
      for (int i = 0; i < 4; i++) rp[i] = ($urandom_range(0, 7) < 3);
      cycle(rp, $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 599) == 0));
    end
    repeat (60) cycle(4'h0, 32'h0, 1'b1, 1'b0);
    check("final_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ai_multiplex.md
Name: ai_multiplex

Overview:
- Transmit-side packer for the AI comparer lane bus: gathers four independent 8-bit byte streams into one 40-bit word.
- Word format: bytes in [31:0]; per-lane valid flags in [35:32]; sequence number in [39:36].
- Each lane has a small FIFO. A word is emitted when all four lanes hold data, or when a timeout expires with at least one lane pending.
- Output is a valid/ready source that feeds the lane demultiplexer on the far side.

Parameters:
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.
- TIMEOUT, 8, cycles a partial word may wait before forced emission; >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- init  in  1  synchronous soft clear: FIFOs, timer, sequence, overflow flags, in-flight word
- data1 / data2 / data3 / data4  in  8 each  lane bytes
- data1_rdy / data2_rdy / data3_rdy / data4_rdy  in  1 each  lane push strobes; no backpressure
- lane_full  out  4  bit n = lane n+1 FIFO full (combinational from count)
- overflow  out  4  sticky; bit n set when a lane n+1 byte is dropped
- avs_s2_inout  out  40  packed word
- avs_s2_valid  out  1  word valid
- avs_s2_ready  in  1  sink accepts word

Behaviour:
- Reset / init values:
  - rst or init: all outputs 0, all FIFOs empty, timer 0, seq 0, state COLLECT.
  - rst has priority over init.
  - Strobes arriving in the rst/init cycle are discarded.
- Word layout:
  - [7:0] lane1, [15:8] lane2, [23:16] lane3, [31:24] lane4.
  - [35:32] lane valid flags, bit 32 = lane1.
  - [39:36] seq.
  - A lane whose flag is 0 carries byte 0x00.
- Lane FIFO push:
  - Push on dataN_rdy.
  - If full and not popped in the same cycle, the byte is dropped and overflow[N-1] is set.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
- State COLLECT:
  - avs_s2_valid = 0.
  - Timer clears to 0 while all FIFOs are empty; otherwise it increments and saturates at TIMEOUT-1.
  - Load condition: all four FIFOs non-empty, or (any non-empty and timer == TIMEOUT-1).
  - On load: pop one entry from every non-empty FIFO, register the word, set flags for the popped lanes, go to SEND.
- State SEND:
  - avs_s2_valid = 1; word held stable until accepted.
  - On valid && ready: seq <= seq+1 (mod 16), timer <= 0, go to COLLECT.
  - Pushes continue during SEND; no pops occur.
- Latency and throughput:
  - Bytes strobed on all four lanes in cycle 0 with empty FIFOs: avs_s2_valid in cycle 2.
  - Single byte, others idle: valid in cycle 1+TIMEOUT.
  - Maximum throughput: one word per 2 cycles.
- init mid-SEND: avs_s2_valid drops the next cycle and the word is lost; seq restarts at 0.
- Word content is never modified while valid=1.

Optional Feature:
- Macro AI_MUX_DROP_CNT_EN.
- Defined:
  - Adds output drop_count [15:0]: total dropped bytes across all lanes.
  - Adds up to 4 per cycle when several lanes overflow simultaneously.
  - Saturates at 0xFFFF; cleared by rst/init.
- Undefined: the port does not exist; overflow flags only.

Test Plan:
- All-lane burst: cycle 0 strobes 0x11, 0x22, 0x33, 0x44, ready=1 -> cycle 2 valid with avs_s2_inout = 0x0F_44332211; accepted; seq becomes 1.
- Partial timeout (TIMEOUT=8): lane3 only, 0xA5 at cycle 0 -> valid at cycle 9 with word 0x04_00A50000; lanes 1, 2, 4 read 0x00.
- Backpressure: ready=0 for 20 cycles after valid -> word and valid stable throughout; 4 more lane1 bytes accepted (FIFO reaches full); ready=1 -> next word holds the oldest pending byte.
- Overflow: 6 lane2 strobes while SEND stalls (DEPTH=4) -> lane_full[1]=1, overflow = 0b0010; drop_count = 2 when AI_MUX_DROP_CNT_EN is defined.
- Sequence wrap: 17 full words accepted back-to-back -> [39:36] goes 0..15, then 0; one word every 2 cycles.
- init while valid=1 -> valid=0 next cycle; FIFOs empty; overflow=0; the next word carries seq 0.
